seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of seven-segment digits (1..8).
REQ-002 SHALL have parameter BIN_W, default 16, binary input width.
REQ-003 SHALL have parameter REFRESH_BIT, default 16; per-digit refresh period is 2^REFRESH_BIT clk cycles.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-005 clk  in  1  system clock, >= 25 MHz.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 value_in  in  BIN_W  value to display, sampled on load.
REQ-008 load  in  1  one-cycle request to capture value_in and bcd_en.
REQ-009 bcd_en  in  1  1 = decimal display, 0 = hex display; sampled with load.
REQ-010 disp_en  in  1  1 = display on, 0 = all anodes and segments off.
REQ-011 busy  out  1  high while a decimal conversion runs.
REQ-012 seg  out  7  active-low segments, bit0 = top, clockwise, bit6 = middle.
REQ-013 an  out  NDIG  active-low one-hot anode select; an[0] = rightmost digit.

Function
REQ-014 load with busy=0 SHALL capture value_in and bcd_en; load with busy=1 SHALL be ignored, with no queueing.
REQ-015 Hex mode: display register SHALL take value_in[4*NDIG-1:0] (zero-extended if BIN_W < 4*NDIG) on the edge after load; busy stays 0.
REQ-016 Decimal mode: busy SHALL rise on the edge after load and stay high for BIN_W cycles, running sequential shift-add-3 with one input bit per cycle, MSB first.
REQ-017 On the final shift edge, busy SHALL fall and the display register SHALL take the BCD result; load-to-update latency is BIN_W+1 cycles.
REQ-018 A 1 shifted out of the top BCD nibble SHALL set a sticky overflow flag; on overflow the display register SHALL be all 4'h9 digits.
REQ-019 Prescaler of REFRESH_BIT bits SHALL count freely; on wrap, digit index SHALL advance, going from NDIG-1 to 0.
REQ-020 an SHALL be all-ones except bit [digit index] = 0; seg SHALL encode the indexed nibble.
REQ-021 Nibble encodings SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 disp_en=0 SHALL force an all-ones and seg=7'b1111111 combinationally; scanning continues underneath.
REQ-023 The display register SHALL hold its last value during a conversion, so no partial result is ever shown.

Reset
REQ-024 While rst_n=0: busy=0, overflow=0, display register=0, prescaler=0, digit index=0, an all-ones, seg=7'b1111111.
REQ-025 Reset asserted mid-conversion SHALL abort it; after release the display shows 0 and the next load starts fresh.

Configuration
REQ-026 Macro SEG_LEADING_ZERO_BLANK_EN defined: digits above the most significant non-zero digit SHALL output seg=7'b1111111 (anode still driven); digit 0 is never blanked; applies in both modes.
REQ-027 SEG_LEADING_ZERO_BLANK_EN undefined: all NDIG digits SHALL always be shown.

Structure
REQ-028 Package seg_pkg SHALL hold the 16-entry segment encoding constant, the SEG_OFF constant (7'b1111111) and the digit-index width function.
REQ-029 The sequential shift-add-3 converter SHALL be sub-module bin2bcd_seq (start/busy/done, result, overflow); scan, encoding and blanking stay in the top module.

Verification
REQ-030 Decimal, value_in=16'd1234: busy high exactly 16 cycles; display digits 1,2,3,4; an=1110 shows seg=0011001.
REQ-031 Decimal, value_in=16'd12345: display 9999; every digit shows seg=0010000.
REQ-032 Hex, value_in=16'hBEEF: busy never rises; display updates 1 cycle after load; digits show F,E,E,b.
REQ-033 Decimal load of 42, then load of 7 at cycle 5 while busy: result 0042, or blank,blank,4,2 with SEG_LEADING_ZERO_BLANK_EN defined.
REQ-034 REFRESH_BIT=2: an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; disp_en=0 gives an=1111, seg=1111111.
REQ-035 rst_n pulsed low at cycle 8 of a conversion of 16'd999: busy drops immediately and display shows 0; a reload yields 0999.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment
// patterns, the blanked-digit pattern, converter state encoding and the
// digit-index width helper.
package seg_pkg;

  // All segments dark (segments are active-low).
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry n is the active-low pattern for nibble n, bit6 (middle) .. bit0 (top).
  localparam logic [15:0][6:0] SEG_ENC = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_e;

  // Width of a digit index; a single-digit display still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. One input bit per cycle,
// MSB first. 'done' and 'result'/'overflow' describe the final shift edge
// so the consumer can capture the result on that same edge.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int NDIG  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   result,
  output logic                overflow
);

  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_e        state_q;
  conv_state_e        state_d;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic               carry_out;
  logic               last_shift;

  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  // Add 3 to every nibble >= 5, then shift left bringing in the next input bit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would infer a latch.
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {carry_out, bcd_next} = {bcd_adj, shift_q[BIN_W-1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop in the
    // design samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state_q <= CONV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: idle until started, run until the last input bit is shifted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE: if (start)      state_d = CONV_RUN;
      CONV_RUN:  if (last_shift) state_d = CONV_IDLE;
      default:                   state_d = CONV_IDLE;
    endcase
  end

  // Outputs: result and overflow reflect the value committed on this edge.
  always_comb begin
    busy     = (state_q == CONV_RUN);
    done     = busy && last_shift;
    result   = bcd_next;
    overflow = ovf_q | carry_out;
  end

  // Datapath: load operand on start, shift once per running cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == CONV_IDLE) begin
      if (start) begin
        shift_q <= bin;
        bcd_q   <= '0;
        ovf_q   <= 1'b0;
        cnt_q   <= '0;
      end
    end else begin
      shift_q <= shift_q << 1;
      bcd_q   <= bcd_next;
      ovf_q   <= ovf_q | carry_out;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display controller with hex or decimal display.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN -- when defined, digits
// above the most significant non-zero digit are blanked (digit 0 never is).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  value_in,
  input  logic              load,
  input  logic              bcd_en,
  input  logic              disp_en,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int DW     = idx_w(NDIG);
  localparam int DISP_W = 4 * NDIG;
  localparam int HEX_W  = (BIN_W < DISP_W) ? BIN_W : DISP_W;

  logic                    accept;
  logic                    conv_start;
  logic                    conv_done;
  logic [DISP_W-1:0]       conv_result;
  logic                    conv_ovf;

  logic [DISP_W-1:0]       hex_val;
  logic [DISP_W-1:0]       all_nines;
  logic [DISP_W-1:0]       disp_q;
  logic [REFRESH_BIT-1:0]  pre_q;
  logic [DW-1:0]           digit_idx;
  logic [3:0]              nib;
  logic                    lead_blank;

  // Loads arriving mid-conversion are dropped, never queued.
  assign accept     = load & ~busy;
  assign conv_start = accept & bcd_en;

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .NDIG  (NDIG)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (conv_start),
    .bin      (value_in),
    .busy     (busy),
    .done     (conv_done),
    .result   (conv_result),
    .overflow (conv_ovf)
  );

  // Hex view of the input (truncated or zero-extended) and the overflow pattern.
  always_comb begin
    hex_val = '0;
    hex_val[HEX_W-1:0] = value_in[HEX_W-1:0];
    for (int i = 0; i < NDIG; i++) begin
      all_nines[4*i +: 4] = 4'h9;
    end
  end

  // Display register: only complete values are written, so a running
  // conversion never shows partial digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else if (accept && !bcd_en) begin
      disp_q <= hex_val;
    end else if (conv_done) begin
      disp_q <= conv_ovf ? all_nines : conv_result;
    end
  end

  // Free-running prescaler; each wrap moves the scan to the next digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      digit_idx <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
      if (&pre_q) begin
        digit_idx <= (digit_idx == DW'(NDIG - 1)) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Select the nibble of the digit being scanned and decide on blanking.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (digit_idx == DW'(i)) nib = disp_q[4*i +: 4];
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin : g_msd
      logic [DW-1:0] msd;
      msd = '0;
      for (int i = 0; i < NDIG; i++) begin
        if (disp_q[4*i +: 4] != 4'h0) msd = DW'(i);
      end
      lead_blank = (digit_idx > msd);
    end
`else
    lead_blank = 1'b0;
`endif
  end

  // Drive anodes and segments; rst_n gates them directly so the display is
  // dark for the whole reset interval, not only after the first edge.
  always_comb begin
    if (!rst_n || !disp_en) begin
      an  = '1;
      seg = SEG_OFF;
    end else begin
      an  = ~(NDIG'(1) << digit_idx);
      seg = lead_blank ? SEG_OFF : SEG_ENC[nib];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed loads, expected frames and busy pulse
// lengths are queued by the stimulus and checked by independent monitors.
module tb_seg_scan_ctrl;

  localparam int NDIG        = 4;
  localparam int BIN_W       = 16;
  localparam int REFRESH_BIT = 2;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BIN_W-1:0]  value_in = '0;
  logic              load = 1'b0;
  logic              bcd_en = 1'b0;
  logic              disp_en = 1'b1;
  logic              busy;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;

  seg_scan_ctrl #(
    .NDIG        (NDIG),
    .BIN_W       (BIN_W),
    .REFRESH_BIT (REFRESH_BIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .load     (load),
    .bcd_en   (bcd_en),
    .disp_en  (disp_en),
    .busy     (busy),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                  name;
    logic [NDIG-1:0][6:0]   segs;
  } frame_t;

  frame_t frame_q[$];
  int     busy_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     frame_req = 0;
  int     frame_done = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // digs: displayed digits, digit 0 in the low nibble; lead: hand-computed
  // mask of leading-zero digits that blank when the feature is enabled.
  function automatic frame_t mk_frame(input string name, input logic [15:0] digs,
                                      input logic [NDIG-1:0] lead);
    frame_t f;
    f.name = name;
    for (int d = 0; d < NDIG; d++) begin
      f.segs[d] = (BLANK_ON && lead[d]) ? 7'b1111111 : enc(digs[4*d +: 4]);
    end
    return f;
  endfunction

  task automatic expect_frame(input frame_t f);
    frame_q.push_back(f);
    frame_req++;
    wait (frame_done == frame_req);
  endtask

  // Frame monitor: capture one scan of every digit and compare per digit.
  initial begin : frame_mon
    frame_t                f;
    logic [NDIG-1:0][6:0]  got;
    logic [NDIG-1:0]       seen;
    forever begin
      wait (frame_req > frame_done);
      f    = frame_q.pop_front();
      seen = '0;
      got  = '0;
      for (int c = 0; c < 64 && seen != '1; c++) begin
        @(posedge clk); #1;
        for (int d = 0; d < NDIG; d++) begin
          if (an == ~(NDIG'(1) << d)) begin
            got[d]  = seg;
            seen[d] = 1'b1;
          end
        end
      end
      check($sformatf("%s_all_digits_scanned", f.name), 32'(seen), 32'({NDIG{1'b1}}));
      for (int d = 0; d < NDIG; d++) begin
        check($sformatf("%s_d%0d", f.name, d), 32'(got[d]), 32'(f.segs[d]));
      end
      frame_done++;
    end
  end

  // Busy monitor: measure every busy pulse and compare with the queued length.
  initial begin : busy_mon
    int len;
    int exp_len;
    len = 0;
    forever begin
      @(posedge clk or negedge rst_n); #1;
      if (busy) begin
        len++;
      end else if (len > 0) begin
        exp_len = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
        check("busy_pulse_len", len, exp_len);
        len = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic do_load(input logic [BIN_W-1:0] v, input logic dec);
    @(negedge clk);
    value_in = v;
    bcd_en   = dec;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Return at the negedge right after the scan wrapped from digit 3 to 0.
  task automatic sync_wrap();
    logic [NDIG-1:0] prev;
    bit              ok;
    prev = '1;
    ok   = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev == 4'b0111) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
    check("sync_wrap_found", 32'(ok), 32'd1);
  endtask

  initial begin : stim
    logic [NDIG-1:0] an_steps [4];
    an_steps = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_an",   32'(an),   32'hF);
    check("rst_seg",  32'(seg),  32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    expect_frame(mk_frame("after_reset", 16'h0000, 4'b1110));

    // Scan order with a 4-cycle refresh period
    sync_wrap();
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check($sformatf("scan_step%0d", k), 32'(an), 32'(an_steps[k]));
    end

    // Display disabled: dark, scanning continues
    @(negedge clk);
    disp_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("disp_off_an",  32'(an),  32'hF);
      check("disp_off_seg", 32'(seg), 32'h7F);
    end
    @(negedge clk);
    disp_en = 1'b1;

    // Decimal 1234
    busy_q.push_back(16);
    do_load(16'd1234, 1'b1);
    repeat (BIN_W + 2) @(negedge clk);
    expect_frame(mk_frame("dec_1234", 16'h1234, 4'b0000));

    // Decimal overflow: 12345 shows 9999
    busy_q.push_back(16);
    do_load(16'd12345, 1'b1);
    repeat (BIN_W + 2) @(negedge clk);
    expect_frame(mk_frame("dec_ovf_12345", 16'h9999, 4'b0000));

    // Hex BEEF: one-cycle update, no busy pulse
    sync_wrap();
    check("hex_hold_old", 32'(seg), 32'(enc(4'h9)));
    value_in = 16'hBEEF;
    bcd_en   = 1'b0;
    load     = 1'b1;
    @(posedge clk); #1;
    check("hex_lat_an",   32'(an),   32'hE);
    check("hex_lat_seg",  32'(seg),  32'(enc(4'hF)));
    check("hex_lat_busy", 32'(busy), 32'd0);
    @(negedge clk);
    load = 1'b0;
    expect_frame(mk_frame("hex_beef", 16'hBEEF, 4'b0000));

    // Decimal 42 with an ignored load of 7 while busy
    busy_q.push_back(16);
    @(negedge clk);
    value_in = 16'd42;
    bcd_en   = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    value_in = 16'd7;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (BIN_W) @(negedge clk);
    expect_frame(mk_frame("dec_42_ignore7", 16'h0042, 4'b1100));

    // Reset during conversion of 999 at cycle 8, then reload
    busy_q.push_back(8);
    @(negedge clk);
    value_in = 16'd999;
    bcd_en   = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an",   32'(an),   32'hF);
    check("abort_seg",  32'(seg),  32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    expect_frame(mk_frame("after_abort", 16'h0000, 4'b1110));
    busy_q.push_back(16);
    do_load(16'd999, 1'b1);
    repeat (BIN_W + 2) @(negedge clk);
    expect_frame(mk_frame("dec_0999", 16'h0999, 4'b1000));

    // Hex 00A0: inner zero stays lit, leading zeros may blank
    do_load(16'h00A0, 1'b0);
    repeat (2) @(negedge clk);
    expect_frame(mk_frame("hex_00a0", 16'h00A0, 4'b1100));

    repeat (4) @(negedge clk);
    check("busy_queue_drained", busy_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
